// File: rtl/cache_range_seq.sv
// Range cache-maintenance sequencer: walks [START, END) one cache line at a time,
// issuing flush/inval requests to the selected cache, controlled over Avalon-MM CSRs.
module cache_range_seq #(
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] amm_address,
  input  logic [31:0] amm_writedata,
  input  logic        amm_read,
  input  logic        amm_write,
  output logic        amm_waitrequest,
  output logic [31:0] amm_readdata,
  output logic        amm_readdatavalid,
  output logic [31:0] icache_req_addr,
  output logic        icache_req_flush,
  output logic        icache_req_inval,
  input  logic        icache_req_ack,
  output logic [31:0] dcache_req_addr,
  output logic        dcache_req_flush,
  output logic        dcache_req_inval,
  input  logic        dcache_req_ack
);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [32:0] LINE_INC  = 33'(LINE_BYTES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_STEP = 2'd2} state_e;

  state_e      state_q;
  logic [31:0] start_q, end_q, cur_q;
  logic [1:0]  op_q;
  logic        tgt_q, done_q, aborted_q, ign_q, abort_pend_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [31:0] ic_addr_q, dc_addr_q;
  logic        ic_flush_q, ic_inval_q, dc_flush_q, dc_inval_q;

  logic        wr_start_s, wr_end_s, wr_cmd_s, wr_status_s;
  logic        cmd_abort_s, cmd_go_s, busy_s, ack_s, empty_s, seq_end_s;
  logic        issue_en_s, issue_tgt_s;
  logic [1:0]  issue_op_s;
  logic [31:0] start_al_s, issue_addr_s, rd_mux_s;
  logic [32:0] sum_s;
  logic        unused_s;

  // Register decode, next-line arithmetic and the request to launch this cycle
  always_comb begin
    wr_start_s  = amm_write && (amm_address[3:2] == 2'd0);
    wr_end_s    = amm_write && (amm_address[3:2] == 2'd1);
    wr_cmd_s    = amm_write && (amm_address[3:2] == 2'd2);
    wr_status_s = amm_write && (amm_address[3:2] == 2'd3);
    cmd_abort_s = wr_cmd_s && amm_writedata[31];
    cmd_go_s    = wr_cmd_s && !amm_writedata[31] && (amm_writedata[1:0] != 2'd0);
    busy_s      = (state_q != S_IDLE);
    ack_s       = tgt_q ? dcache_req_ack : icache_req_ack;
    start_al_s  = start_q & LINE_MASK;
    empty_s     = (start_al_s >= end_q);
    // The 33-bit sum catches a range ending at the top of the address space
    sum_s       = {1'b0, cur_q} + LINE_INC;
    seq_end_s   = sum_s[32] || (sum_s >= {1'b0, end_q}) || abort_pend_q || cmd_abort_s;
    issue_en_s   = 1'b0;
    issue_addr_s = cur_q;
    issue_op_s   = op_q;
    issue_tgt_s  = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_go_s && !empty_s) begin
          issue_en_s   = 1'b1;
          issue_addr_s = start_al_s;
          issue_op_s   = amm_writedata[1:0];
          issue_tgt_s  = amm_writedata[2];
        end else begin
          issue_en_s = 1'b0;
        end
      end
      S_STEP: begin
        if (!seq_end_s) begin
          issue_en_s   = 1'b1;
          issue_addr_s = sum_s[31:0];
        end else begin
          issue_en_s = 1'b0;
        end
      end
      default: issue_en_s = 1'b0;
    endcase
    case (amm_address[3:2])
      2'd0:    rd_mux_s = start_q;
      2'd1:    rd_mux_s = end_q;
      2'd3:    rd_mux_s = {28'd0, ign_q, aborted_q, done_q, busy_s};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Sequencer FSM, CSR storage and registered request strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 32'd0;
      end_q        <= 32'd0;
      cur_q        <= 32'd0;
      op_q         <= 2'd0;
      tgt_q        <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ign_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      ic_addr_q    <= 32'd0;
      dc_addr_q    <= 32'd0;
      ic_flush_q   <= 1'b0;
      ic_inval_q   <= 1'b0;
      dc_flush_q   <= 1'b0;
      dc_inval_q   <= 1'b0;
    end else begin
      if (busy_s && (wr_start_s || wr_end_s || (wr_cmd_s && !amm_writedata[31]))) begin
        ign_q <= 1'b1;
      end else if (wr_status_s) begin
        ign_q <= 1'b0;
      end
      if (!busy_s && wr_start_s) start_q <= amm_writedata;
      if (!busy_s && wr_end_s)   end_q   <= amm_writedata;
      case (state_q)
        S_IDLE: begin
          if (cmd_go_s) begin
            op_q         <= amm_writedata[1:0];
            tgt_q        <= amm_writedata[2];
            cur_q        <= start_al_s;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= empty_s;
            state_q      <= empty_s ? S_IDLE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_abort_s) abort_pend_q <= 1'b1;
          if (ack_s)       state_q      <= S_STEP;
        end
        S_STEP: begin
          cur_q <= sum_s[31:0];
          if (seq_end_s) begin
            state_q      <= S_IDLE;
            abort_pend_q <= 1'b0;
            if (abort_pend_q || cmd_abort_s) aborted_q <= 1'b1;
            else                             done_q    <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (issue_en_s) begin
        if (issue_tgt_s) begin
          dc_addr_q  <= issue_addr_s;
          dc_flush_q <= issue_op_s[1];
          dc_inval_q <= issue_op_s[0];
        end else begin
          ic_addr_q  <= issue_addr_s;
          ic_flush_q <= issue_op_s[1];
          ic_inval_q <= issue_op_s[0];
        end
      end else if ((state_q == S_ISSUE) && ack_s) begin
        ic_flush_q <= 1'b0;
        ic_inval_q <= 1'b0;
        dc_flush_q <= 1'b0;
        dc_inval_q <= 1'b0;
      end
    end
  end

  // Read path: data sampled from pre-write state, valid one cycle after the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= amm_read;
      if (amm_read) rdata_q <= rd_mux_s;
    end
  end

  assign unused_s          = ^{amm_address[31:4], amm_address[1:0]};
  assign amm_waitrequest   = 1'b0;
  assign amm_readdata      = rdata_q;
  assign amm_readdatavalid = rvalid_q;
  assign icache_req_addr   = ic_addr_q;
  assign icache_req_flush  = ic_flush_q;
  assign icache_req_inval  = ic_inval_q;
  assign dcache_req_addr   = dc_addr_q;
  assign dcache_req_flush  = dc_flush_q;
  assign dcache_req_inval  = dc_inval_q;
endmodule
